ctr_buffer: RTL and testbench

Circular Control Transfer Records storage: the consuming end of the CTR record stream. Accepts up to `NrCommitPorts` records per cycle from the CTR emitter (source/target/data triplets already filtered by `ctrctl`) and holds the most recent `Depth` of them. Serves indexed, logically-ordered reads to the CSR regfile's indirect `ctrsource`/`ctrtarget`/`ctrdata` access path, and supports clear (`sctrclr`) and freeze.

---
 rtl/ctr_buffer.sv | 93 +++++++++
 tb/tb_ctr_buffer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ctr_buffer.sv
// ctr_buffer: circular store of the most recent Depth CTR records with indexed, newest-first reads
module ctr_buffer #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned Depth         = 16,
  parameter int unsigned SrcW          = 64,
  parameter int unsigned TgtW          = 64,
  parameter int unsigned DataW         = 64
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NrCommitPorts-1:0]                  rec_valid_i,
  input  logic [NrCommitPorts-1:0][SrcW-1:0]        rec_source_i,
  input  logic [NrCommitPorts-1:0][TgtW-1:0]        rec_target_i,
  input  logic [NrCommitPorts-1:0][DataW-1:0]       rec_data_i,
  input  logic                                      freeze_i,
  input  logic                                      clear_i,
  input  logic                                      rd_req_i,
  input  logic [7:0]                                rd_idx_i,
  output logic                                      rd_valid_o,
  output logic [SrcW-1:0]                           rd_source_o,
  output logic [TgtW-1:0]                           rd_target_o,
  output logic [DataW-1:0]                          rd_data_o,
  output logic [$clog2(Depth)-1:0]                  wr_ptr_o,
  output logic [$clog2(Depth):0]                    count_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = $clog2(NrCommitPorts + 1);
  logic [SrcW-1:0]                    r_src [Depth];
  logic [TgtW-1:0]                    r_tgt [Depth];
  logic [DataW-1:0]                   r_dat [Depth];
  logic [Depth-1:0]                   r_vld;
  logic [AW-1:0]                      r_wr_ptr;
  logic [AW:0]                        r_count;
  logic [PW-1:0]                      w_pop;
  logic [NrCommitPorts-1:0][AW-1:0]   w_slot;
  logic [AW:0]                        w_count_nxt;
  logic [AW-1:0]                      w_rd_slot;
  logic                               w_rd_hit;
  assign wr_ptr_o = r_wr_ptr;
  assign count_o  = r_count;
  // Pack valid ports contiguously after the write pointer; map logical read index to a physical slot
  always_comb begin
    w_pop  = '0;
    w_slot = '0;
    for (int k = 0; k < NrCommitPorts; k++) begin
      w_slot[k] = r_wr_ptr + AW'(w_pop);
      w_pop     = w_pop + PW'(rec_valid_i[k]);
    end
    w_count_nxt = (32'(r_count) + 32'(w_pop) > Depth) ? (AW+1)'(Depth) : r_count + (AW+1)'(w_pop);
    w_rd_slot   = r_wr_ptr - AW'(1) - rd_idx_i[AW-1:0];
    w_rd_hit    = (32'(rd_idx_i) < Depth) && r_vld[w_rd_slot];
  end
  // Record storage: clear beats write, freeze holds everything; later ports overwrite earlier ones on a shared slot
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int i = 0; i < Depth; i++) begin
        r_src[i] <= '0;
        r_tgt[i] <= '0;
        r_dat[i] <= '0;
      end
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (!freeze_i) begin
      for (int k = 0; k < NrCommitPorts; k++) begin
        if (rec_valid_i[k]) begin
          r_src[w_slot[k]] <= rec_source_i[k];
          r_tgt[w_slot[k]] <= rec_target_i[k];
          r_dat[w_slot[k]] <= rec_data_i[k];
          r_vld[w_slot[k]] <= 1'b1;
        end
      end
      r_wr_ptr <= r_wr_ptr + AW'(w_pop);
      r_count  <= w_count_nxt;
    end
  end
  // Read response from pre-update contents; data holds between requests
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_o  <= 1'b0;
      rd_source_o <= '0;
      rd_target_o <= '0;
      rd_data_o   <= '0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) begin
        rd_source_o <= w_rd_hit ? r_src[w_rd_slot] : '0;
        rd_target_o <= w_rd_hit ? r_tgt[w_rd_slot] : '0;
        rd_data_o   <= w_rd_hit ? r_dat[w_rd_slot] : '0;
      end
    end
  end
endmodule

// File: tb/tb_ctr_buffer.sv
// tb_ctr_buffer: directed stimulus against a newest-first record history model of ctr_buffer
module tb_ctr_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic             rst = 1'b1, freeze = 1'b0, clear = 1'b0, rd_req = 1'b0;
  logic [1:0]       vld = '0;
  logic [1:0][63:0] src = '0, tgt = '0, dat = '0;
  logic [7:0]       idx = '0;
  logic             rd_valid;
  logic [63:0]      rd_src, rd_tgt, rd_dat;
  logic [3:0]       wr_ptr;
  logic [4:0]       count;
  int n_chk = 0, n_fail = 0;
  ctr_buffer #(.NrCommitPorts(2), .Depth(16), .SrcW(64), .TgtW(64), .DataW(64)) dut (
    .clk_i(clk), .rst_i(rst), .rec_valid_i(vld), .rec_source_i(src), .rec_target_i(tgt),
    .rec_data_i(dat), .freeze_i(freeze), .clear_i(clear), .rd_req_i(rd_req), .rd_idx_i(idx),
    .rd_valid_o(rd_valid), .rd_source_o(rd_src), .rd_target_o(rd_tgt), .rd_data_o(rd_dat),
    .wr_ptr_o(wr_ptr), .count_o(count)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // History model: newest record at the front, never more than 16 kept
  logic [63:0] q_src[$], q_tgt[$], q_dat[$];
  int          nwr = 0;
  bit          armed = 0;
  logic        e_v = 0;
  logic [63:0] e_s = 0, e_t = 0, e_d = 0;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      q_src.delete(); q_tgt.delete(); q_dat.delete();
      nwr = 0; e_v = 0; e_s = 0; e_t = 0; e_d = 0; armed = 1;
    end else begin
      e_v = rd_req;
      if (rd_req) begin
        if (int'(idx) < q_src.size()) begin
          e_s = q_src[idx]; e_t = q_tgt[idx]; e_d = q_dat[idx];
        end else begin
          e_s = 0; e_t = 0; e_d = 0;
        end
      end
      if (clear) begin
        q_src.delete(); q_tgt.delete(); q_dat.delete();
        nwr = 0;
      end else if (!freeze) begin
        for (int k = 0; k < 2; k++) begin
          if (vld[k]) begin
            q_src.push_front(src[k]); q_tgt.push_front(tgt[k]); q_dat.push_front(dat[k]);
            nwr++;
            if (q_src.size() > 16) begin
              void'(q_src.pop_back()); void'(q_tgt.pop_back()); void'(q_dat.pop_back());
            end
          end
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("m_count", 64'(count), 64'(q_src.size()));
      chk("m_wr_ptr", 64'(wr_ptr), 64'(nwr % 16));
      chk("m_rd_valid", 64'(rd_valid), 64'(e_v));
      chk("m_rd_source", rd_src, e_s);
      chk("m_rd_target", rd_tgt, e_t);
      chk("m_rd_data", rd_dat, e_d);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input int i);
    rd_req = 1'b1;
    idx = 8'(i);
    step();
    rd_req = 1'b0;
  endtask
  task automatic put(input logic [1:0] v, input logic [63:0] s0, input logic [63:0] t0,
                     input logic [63:0] s1, input logic [63:0] t1);
    vld = v;
    src[0] = s0; tgt[0] = t0; dat[0] = s0 ^ 64'hD0;
    src[1] = s1; tgt[1] = t1; dat[1] = s1 ^ 64'hD0;
    step();
    vld = '0;
  endtask
  initial begin
    step(); step();
    rst = 1'b0;
    chk("rst_count", 64'(count), 0);
    chk("rst_wr_ptr", 64'(wr_ptr), 0);
    chk("rst_rd_valid", 64'(rd_valid), 0);
    rd(0);
    chk("empty_rd_valid", 64'(rd_valid), 1);
    chk("empty_rd_source", rd_src, 0);
    put(2'b01, 64'h1001, 64'h2000, 64'h0, 64'h0);
    chk("one_count", 64'(count), 1);
    chk("one_wr_ptr", 64'(wr_ptr), 1);
    rd(0);
    chk("one_idx0_source", rd_src, 64'h1001);
    chk("one_idx0_target", rd_tgt, 64'h2000);
    chk("one_idx0_data", rd_dat, 64'h10D1);
    rd(1);
    chk("one_idx1_valid", 64'(rd_valid), 1);
    chk("one_idx1_source", rd_src, 0);
    put(2'b11, 64'hA, 64'hAA, 64'hB, 64'hBB);
    chk("dual_wr_ptr", 64'(wr_ptr), 3);
    rd(0); chk("dual_idx0_B", rd_src, 64'hB);
    rd(1); chk("dual_idx1_A", rd_src, 64'hA);
    put(2'b10, 64'h0, 64'h0, 64'hC, 64'hCC);
    chk("gap_wr_ptr", 64'(wr_ptr), 4);
    rd(0); chk("gap_idx0_C", rd_src, 64'hC);
    rd(1); chk("gap_idx1_B", rd_src, 64'hB);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_count", 64'(count), 0);
    for (int i = 0; i < 20; i++) put(2'b01, 64'((i << 1) | 1), 64'h8000 + 64'(i), 64'h0, 64'h0);
    chk("wrap_count", 64'(count), 16);
    chk("wrap_wr_ptr", 64'(wr_ptr), 4);
    for (int i = 0; i <= 16; i++) begin
      rd_req = 1'b1;
      idx = 8'(i);
      step();
      if (i == 0) chk("wrap_idx0", rd_src, 64'((19 << 1) | 1));
      if (i == 15) chk("wrap_idx15", rd_src, 64'((4 << 1) | 1));
      if (i == 16) chk("wrap_idx16_zero", rd_src, 0);
    end
    rd_req = 1'b0;
    clear = 1'b1; vld = 2'b01; src[0] = 64'h5555; rd_req = 1'b1; idx = 8'd0;
    step();
    clear = 1'b0; vld = '0; rd_req = 1'b0;
    chk("clr_rd_old", rd_src, 64'((19 << 1) | 1));
    chk("clr_count", 64'(count), 0);
    chk("clr_wr_ptr", 64'(wr_ptr), 0);
    rd(0); chk("clr_idx0_zero", rd_src, 0);
    for (int i = 0; i < 10; i++) put(2'b11, 64'h100 + 64'(2*i), 64'h1, 64'h101 + 64'(2*i), 64'h2);
    chk("dual_wrap_count", 64'(count), 16);
    chk("dual_wrap_ptr", 64'(wr_ptr), 4);
    rd(0); chk("dual_wrap_idx0", rd_src, 64'h113);
    rd(15); chk("dual_wrap_idx15", rd_src, 64'h104);
    freeze = 1'b1;
    put(2'b11, 64'hF0, 64'h0, 64'hF1, 64'h0);
    put(2'b01, 64'hF2, 64'h0, 64'h0, 64'h0);
    put(2'b10, 64'h0, 64'h0, 64'hF3, 64'h0);
    chk("frz_count", 64'(count), 16);
    chk("frz_wr_ptr", 64'(wr_ptr), 4);
    rd(0); chk("frz_idx0", rd_src, 64'h113);
    freeze = 1'b0;
    rd_req = 1'b1; idx = 8'd0; rst = 1'b1;
    step();
    rst = 1'b0; rd_req = 1'b0;
    chk("rst2_rd_valid", 64'(rd_valid), 0);
    chk("rst2_count", 64'(count), 0);
    chk("rst2_wr_ptr", 64'(wr_ptr), 0);
    chk("rst2_source", rd_src, 0);
    rd(0); chk("rst2_idx0_zero", rd_src, 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
